// File: rtl/note_detector.sv
// Tone recognizer: measures AUDIO_IN half-periods and locks onto one of four
// notes after LOCK_N consecutive matching half-periods.
module note_detector #(
    parameter int HP0     = 13514,
    parameter int HP1     = 11363,
    parameter int HP2     = 9020,
    parameter int HP3     = 7584,
    parameter int TOL     = 64,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 16383
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       AUDIO_IN,
    output logic [1:0] NOTE_OUT,
    output logic       NOTE_VALID,
    output logic       NOTE_CHANGE,
    output logic       SAMPLE_ERR
);

    // state   | meaning
    // IDLE    | no reference edge yet (after reset or timeout)
    // ACQUIRE | measuring, counting consecutive matches of cand
    // LOCKED  | NOTE_OUT is being received
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int MW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
    localparam int HP [4] = '{HP0, HP1, HP2, HP3};

    state_t          state;
    logic            sync1, sync2, hist;
    logic            edge_p;
    logic [CW-1:0]   cnt;
    logic [MW-1:0]   mc, mc_new;
    logic [1:0]      cand, k;
    logic            hit, lock_now, timeout;
    int              h;

    assign edge_p = sync2 ^ hist;

    // cnt holds the number of cycles elapsed since the last edge, so on an
    // edge it is the measured half-period directly.
    always_comb begin
        h   = int'(cnt);
        hit = 1'b0;
        k   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (h >= HP[i] - TOL && h <= HP[i] + TOL) begin
                hit = 1'b1;
                k   = 2'(i);
            end
        end
        mc_new   = (state == ACQUIRE && (k == cand || mc == '0)) ? mc + 1'b1 : MW'(1);
        lock_now = int'(mc_new) >= LOCK_N;
        timeout  = h >= TIMEOUT;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            hist        <= 1'b0;
            cnt         <= '0;
            mc          <= '0;
            cand        <= 2'd0;
            NOTE_OUT    <= 2'd0;
            NOTE_VALID  <= 1'b0;
            NOTE_CHANGE <= 1'b0;
            SAMPLE_ERR  <= 1'b0;
        end else begin
            sync1       <= AUDIO_IN;
            sync2       <= sync1;
            hist        <= sync2;
            NOTE_CHANGE <= 1'b0;
            SAMPLE_ERR  <= 1'b0;

            if (edge_p) begin
                cnt <= CW'(1);
            end else if (cnt != {CW{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end

            if (edge_p) begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                        mc    <= '0;
                    end
                    default: begin
                        if (!hit) begin
                            state      <= ACQUIRE;
                            mc         <= '0;
                            NOTE_VALID <= 1'b0;
                            SAMPLE_ERR <= !SAMPLE_ERR;
                        end else if (state == LOCKED && k == NOTE_OUT) begin
                            state <= LOCKED;
                        end else if (lock_now) begin
                            state       <= LOCKED;
                            cand        <= k;
                            mc          <= '0;
                            NOTE_OUT    <= k;
                            NOTE_VALID  <= 1'b1;
                            NOTE_CHANGE <= !NOTE_CHANGE;
                        end else begin
                            state      <= ACQUIRE;
                            cand       <= k;
                            mc         <= mc_new;
                            NOTE_VALID <= 1'b0;
                        end
                    end
                endcase
            end else if (timeout && state != IDLE) begin
                state      <= IDLE;
                mc         <= '0;
                NOTE_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector with scaled-down half-periods: a directed table,
// timeout/reset sequences and a randomized run against a queue-based model.
module tb_note_detector;

    localparam int TOL     = 6;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 400;
    localparam int HPV [4] = '{200, 170, 140, 130};

    logic       clk, rst_n, audio;
    logic [1:0] note_out;
    logic       note_valid, note_change, sample_err;

    int n_vec = 0;
    int n_err = 0;
    int since = 0;

    // model: phase 0 idle, 1 acquiring, 2 locked; q holds matched notes since
    // the last reference edge, miss or lock
    int m_phase = 0;
    int m_note  = 0;
    bit m_nc    = 0;
    bit m_se    = 0;
    int q[$];

    typedef struct {
        int h;
        bit v;
        int note;
        bit nc;
        bit se;
    } vec_t;
    vec_t tab[$];

    note_detector #(
        .HP0(200), .HP1(170), .HP2(140), .HP3(130),
        .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .AUDIO_IN(audio),
        .NOTE_OUT(note_out),
        .NOTE_VALID(note_valid),
        .NOTE_CHANGE(note_change),
        .SAMPLE_ERR(sample_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int classify(input int h);
        for (int j = 0; j < 4; j++) begin
            if ((h > HPV[j] ? h - HPV[j] : HPV[j] - h) <= TOL) return j;
        end
        return -1;
    endfunction

    function automatic bit tail_locked();
        int n;
        n = q.size();
        if (n < LOCK_N) return 0;
        for (int j = n - LOCK_N; j < n; j++) begin
            if (q[j] != q[n-1]) return 0;
        end
        return 1;
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_note  = 0;
        m_nc    = 0;
        m_se    = 0;
        q.delete();
    endfunction

    function automatic void model_timeout(input int h);
        if (m_phase != 0 && h > TIMEOUT) m_phase = 0;
    endfunction

    function automatic void model_edge(input int h);
        int k;
        m_nc = 0;
        m_se = 0;
        if (m_phase == 0) begin
            m_phase = 1;
            q.delete();
            return;
        end
        k = classify(h);
        if (k < 0) begin
            q.delete();
            m_se    = 1;
            m_phase = 1;
        end else if (!(m_phase == 2 && k == m_note)) begin
            if (m_phase == 2) q.delete();
            q.push_back(k);
            if (tail_locked()) begin
                m_phase = 2;
                m_note  = k;
                m_nc    = 1;
                q.delete();
            end else begin
                m_phase = 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input bit ev, input int en, input bit enc, input bit ese);
        logic [1:0] en2;
        en2 = en[1:0];
        n_vec++;
        if (note_valid !== ev || note_out !== en2 || note_change !== enc || sample_err !== ese) begin
            n_err++;
            $display("FAIL %s @%0t: got valid=%b note=%0d change=%b err=%b, want valid=%b note=%0d change=%b err=%b",
                     tag, $time, note_valid, note_out, note_change, sample_err, ev, en, enc, ese);
        end
    endtask

    // Toggle AUDIO_IN h cycles after the previous toggle, then check that
    // outputs hold for two edges and update on the third.
    task automatic edge_step(input int h);
        bit pv;
        int pn;
        repeat (h - since) @(posedge clk);
        #1 audio = ~audio;
        model_timeout(h);
        pv = (m_phase == 2);
        pn = m_note;
        model_edge(h);
        repeat (2) @(posedge clk);
        #1 chk("latency", pv, pn, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("edge", m_phase == 2, m_note, m_nc, m_se);
    endtask

    task automatic post_step();
        @(posedge clk);
        #1 chk("pulse_width", m_phase == 2, m_note, 1'b0, 1'b0);
        since = 4;
    endtask

    task automatic step(input int h);
        edge_step(h);
        post_step();
    endtask

    initial begin
        rst_n = 1'b1;
        audio = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset", 1'b0, 0, 1'b0, 1'b0);
        model_reset();
        rst_n = 1'b1;
        since = 0;

        // h, valid, note, change, err
        tab.push_back('{200, 0, 0, 0, 0});
        tab.push_back('{200, 0, 0, 0, 0});
        tab.push_back('{200, 0, 0, 0, 0});
        tab.push_back('{200, 0, 0, 0, 0});
        tab.push_back('{200, 1, 0, 1, 0});
        tab.push_back('{200, 1, 0, 0, 0});
        tab.push_back('{130, 0, 0, 0, 0});
        tab.push_back('{130, 0, 0, 0, 0});
        tab.push_back('{130, 0, 0, 0, 0});
        tab.push_back('{130, 1, 3, 1, 0});
        tab.push_back('{140, 0, 3, 0, 0});
        tab.push_back('{140, 0, 3, 0, 0});
        tab.push_back('{140, 0, 3, 0, 0});
        tab.push_back('{140, 1, 2, 1, 0});
        tab.push_back('{135, 1, 2, 0, 0});
        tab.push_back('{131, 0, 2, 0, 0});
        tab.push_back('{185, 0, 2, 0, 1});
        tab.push_back('{185, 0, 2, 0, 1});
        tab.push_back('{176, 0, 2, 0, 0});
        tab.push_back('{176, 0, 2, 0, 0});
        tab.push_back('{176, 0, 2, 0, 0});
        tab.push_back('{176, 1, 1, 1, 0});
        tab.push_back('{177, 0, 1, 0, 1});
        tab.push_back('{177, 0, 1, 0, 1});
        tab.push_back('{164, 0, 1, 0, 0});
        tab.push_back('{164, 0, 1, 0, 0});
        tab.push_back('{164, 0, 1, 0, 0});
        tab.push_back('{164, 1, 1, 1, 0});
        tab.push_back('{400, 0, 1, 0, 1});
        tab.push_back('{401, 0, 1, 0, 0});
        tab.push_back('{170, 0, 1, 0, 0});
        tab.push_back('{163, 0, 1, 0, 1});

        foreach (tab[i]) begin
            edge_step(tab[i].h);
            chk($sformatf("table[%0d]", i), tab[i].v, tab[i].note, tab[i].nc, tab[i].se);
            post_step();
        end

        // lock on note 0, then hold AUDIO_IN and watch the timeout edge
        repeat (4) step(200);
        chk("timeout_locked", 1'b1, 0, 1'b0, 1'b0);
        repeat (398) @(posedge clk);
        #1 chk("timeout_before", 1'b1, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("timeout_drop", 1'b0, 0, 1'b0, 1'b0);
        since = 403;
        edge_step(500);
        chk("timeout_ref_only", 1'b0, 0, 1'b0, 1'b0);
        post_step();

        // lock on note 1, then async reset in the middle of a half-period
        repeat (4) step(170);
        chk("pre_reset_lock", 1'b1, 1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", 1'b0, 0, 1'b0, 1'b0);
        model_reset();
        audio = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        since = 0;
        repeat (4) step(170);
        chk("relock_early", 1'b0, 0, 1'b0, 1'b0);
        edge_step(170);
        chk("relock", 1'b1, 1, 1'b1, 1'b0);
        post_step();

        // randomized runs of notes, misses and timeouts
        for (int r = 0; r < 60; r++) begin
            int mode, kk, len;
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                step($urandom_range(395, 420));
            end else if (mode == 1) begin
                step($urandom_range(177, 193));
            end else begin
                kk  = $urandom_range(0, 3);
                len = $urandom_range(1, 6);
                for (int j = 0; j < len; j++) begin
                    step(HPV[kk] + $urandom_range(0, 2 * TOL + 4) - TOL - 2);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
